// File: rtl/utils_top.sv
// Shared writeback-stage definitions: opcodes, load funct3 codes, exception bits
// and the stage-register record.
package utils_top;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Bit positions inside the 2-bit {oob, mis} exception vector
  typedef enum logic {
    EXC_MIS = 1'b0,
    EXC_OOB = 1'b1
  } exc_cause_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] dat;
    logic [1:0]  lsb;
    logic [1:0]  exc;
  } wb_stage_t;

endpackage

// File: rtl/writeback_load_align.sv
// Combinational load-data alignment: picks the addressed byte/half of the raw
// memory word and sign- or zero-extends it.
module wb_load_align
  import utils_top::*;
(
  input  logic [31:0] dat,
  input  logic [1:0]  lsb,
  input  logic [2:0]  funct3,
  input  logic        is_load,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dat[{lsb, 3'b000} +: 8];
    half_sel = lsb[1] ? dat[31:16] : dat[15:0];
    aligned  = dat;
    if (is_load) begin
      unique case (funct3)
        F3_LB:   aligned = {{24{byte_sel[7]}}, byte_sel};
        F3_LBU:  aligned = {24'h0, byte_sel};
        F3_LH:   aligned = {{16{half_sel[15]}}, half_sel};
        F3_LHU:  aligned = {16'h0, half_sel};
        default: aligned = dat;  // LW and reserved encodings pass the word through
      endcase
    end
  end

endmodule

// File: rtl/writeback_top.sv
// Writeback stage: registers the memory-access outputs, drives the register
// file / forwarding port, retires instructions and captures the first exception.
module writeback_top
  import utils_top::*;
#(
  parameter int          RETIRE_CNT_W = 64,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ma_vld,
  input  logic [31:0]             ma_pc,
  input  logic [31:0]             ma_inst,
  input  logic [31:0]             ma_dat,
  input  logic [1:0]              ma_addr_lsb,
  input  logic [1:0]              ma_exc,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    exc_clr,
  output logic                    rf_we,
  output logic [4:0]              rf_dst,
  output logic [31:0]             rf_dat,
  output logic                    fwd_we,
  output logic [4:0]              fwd_dst,
  output logic [31:0]             fwd_dat,
  output logic                    retire_vld,
  output logic [31:0]             retire_pc,
  output logic [RETIRE_CNT_W-1:0] instret_cnt,
  output logic                    exc_vld,
  output logic [1:0]              exc_cause,
  output logic [31:0]             exc_pc
);

  wb_stage_t stg;
  wb_stage_t ma_req;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_load;
  logic [31:0] ld_dat;
  logic        adv;
  logic        commit;
  logic        exc_evt;
  logic        unused_inst;

  assign ma_req = '{vld: ma_vld, pc: ma_pc, inst: ma_inst, dat: ma_dat,
                    lsb: ma_addr_lsb, exc: ma_exc};

  // Flush beats stall so a bubble replaces even a held instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '{vld: 1'b0, pc: '0, inst: NOP_INST, dat: '0, lsb: '0, exc: '0};
    end else if (flush) begin
      stg.vld  <= 1'b0;
      stg.inst <= NOP_INST;
    end else if (!stall) begin
      stg <= ma_req;
    end
  end

  assign opcode      = stg.inst[6:0];
  assign rd          = stg.inst[11:7];
  assign funct3      = stg.inst[14:12];
  assign is_load     = (opcode == OP_LOAD);
  assign unused_inst = ^stg.inst[31:15];

  wb_load_align u_align (
    .dat     (stg.dat),
    .lsb     (stg.lsb),
    .funct3  (funct3),
    .is_load (is_load),
    .aligned (ld_dat)
  );

  // An instruction leaves the stage only when not held; exceptions suppress commit
  assign adv     = stg.vld & ~stall;
  assign commit  = adv & ~|stg.exc;
  assign exc_evt = adv & |stg.exc;

  assign rf_we   = commit & (opcode != OP_STORE) & (opcode != OP_BRANCH) & (rd != 5'd0);
  assign rf_dst  = rd;
  assign rf_dat  = ld_dat;
  assign fwd_we  = rf_we;
  assign fwd_dst = rf_dst;
  assign fwd_dat = rf_dat;

  assign retire_vld = commit;
  assign retire_pc  = stg.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_cnt <= '0;
    else if (commit) instret_cnt <= instret_cnt + 1'b1;
  end

  // First exception wins; a clear in the same cycle as a new event lets it in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_vld   <= 1'b0;
      exc_cause <= '0;
      exc_pc    <= '0;
    end else if (exc_evt && (!exc_vld || exc_clr)) begin
      exc_vld   <= 1'b1;
      exc_cause <= stg.exc;
      exc_pc    <= stg.pc;
    end else if (exc_clr) begin
      exc_vld   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_top.sv
// Bench for writeback_top: directed vector table, hand sequences for stall,
// exception, flush and wrap corners, then random traffic against a reference model.
module tb_writeback_top;

  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_BR   = 7'b1100011, OPC_OP    = 7'b0110011,
                         OPC_IMM  = 7'b0010011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ma_vld = 1'b0;
  logic [31:0] ma_pc = '0, ma_inst = NOP, ma_dat = '0;
  logic [1:0]  ma_addr_lsb = '0, ma_exc = '0;
  logic        stall = 1'b0, flush = 1'b0, exc_clr = 1'b0;

  logic        rf_we, fwd_we, retire_vld, exc_vld;
  logic [4:0]  rf_dst, fwd_dst;
  logic [31:0] rf_dat, fwd_dat, retire_pc, exc_pc;
  logic [63:0] instret_cnt;
  logic [1:0]  exc_cause;

  logic        unused_s_rf_we, unused_s_fwd_we, unused_s_ret, unused_s_exc_vld;
  logic [4:0]  unused_s_rf_dst, unused_s_fwd_dst;
  logic [31:0] unused_s_rf_dat, unused_s_fwd_dat, unused_s_ret_pc, unused_s_exc_pc;
  logic [1:0]  unused_s_exc_cause;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  writeback_top dut (
    .clk(clk), .rst_n(rst_n), .ma_vld(ma_vld), .ma_pc(ma_pc), .ma_inst(ma_inst),
    .ma_dat(ma_dat), .ma_addr_lsb(ma_addr_lsb), .ma_exc(ma_exc), .stall(stall),
    .flush(flush), .exc_clr(exc_clr), .rf_we(rf_we), .rf_dst(rf_dst), .rf_dat(rf_dat),
    .fwd_we(fwd_we), .fwd_dst(fwd_dst), .fwd_dat(fwd_dat), .retire_vld(retire_vld),
    .retire_pc(retire_pc), .instret_cnt(instret_cnt), .exc_vld(exc_vld),
    .exc_cause(exc_cause), .exc_pc(exc_pc)
  );

  // Narrow-counter copy exercises wrap-around in a few retirements
  writeback_top #(.RETIRE_CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .ma_vld(ma_vld), .ma_pc(ma_pc), .ma_inst(ma_inst),
    .ma_dat(ma_dat), .ma_addr_lsb(ma_addr_lsb), .ma_exc(ma_exc), .stall(stall),
    .flush(flush), .exc_clr(exc_clr), .rf_we(unused_s_rf_we), .rf_dst(unused_s_rf_dst),
    .rf_dat(unused_s_rf_dat), .fwd_we(unused_s_fwd_we), .fwd_dst(unused_s_fwd_dst),
    .fwd_dat(unused_s_fwd_dat), .retire_vld(unused_s_ret), .retire_pc(unused_s_ret_pc),
    .instret_cnt(s_cnt), .exc_vld(unused_s_exc_vld), .exc_cause(unused_s_exc_cause),
    .exc_pc(unused_s_exc_pc)
  );

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the instruction sitting in writeback plus architectural state
  logic        m_vld;
  logic [31:0] m_pc, m_inst, m_dat;
  logic [1:0]  m_lsb, m_exc;
  logic [63:0] m_cnt;
  logic        m_exc_vld;
  logic [1:0]  m_cause;
  logic [31:0] m_epc;

  function automatic logic [31:0] ref_dat(input logic [31:0] inst, input logic [31:0] d,
                                          input logic [1:0] lsb);
    logic [31:0] b, h;
    b = (d >> (8 * lsb)) & 32'hFF;
    h = (d >> (16 * lsb[1])) & 32'hFFFF;
    if (inst[6:0] != OPC_LOAD) return d;
    case (inst[14:12])
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    m_vld = 0; m_pc = 0; m_inst = NOP; m_dat = 0; m_lsb = 0; m_exc = 0;
    m_cnt = 0; m_exc_vld = 0; m_cause = 0; m_epc = 0;
  endtask

  task automatic check_model();
    logic cm, we;
    cm = m_vld && !stall && (m_exc == 2'b00);
    we = cm && m_inst[6:0] != OPC_STORE && m_inst[6:0] != OPC_BR && m_inst[11:7] != 0;
    chk("rf_we", rf_we, we);
    chk("fwd_we", fwd_we, we);
    if (we) begin
      chk("rf_dst", rf_dst, m_inst[11:7]);
      chk("fwd_dst", fwd_dst, m_inst[11:7]);
      chk("rf_dat", rf_dat, ref_dat(m_inst, m_dat, m_lsb));
      chk("fwd_dat", fwd_dat, ref_dat(m_inst, m_dat, m_lsb));
    end
    chk("retire_vld", retire_vld, cm);
    if (cm) chk("retire_pc", retire_pc, m_pc);
    chk("instret_cnt", instret_cnt, m_cnt);
    chk("instret_small", s_cnt, m_cnt % 8);
    chk("exc_vld", exc_vld, m_exc_vld);
    if (m_exc_vld) begin
      chk("exc_cause", exc_cause, m_cause);
      chk("exc_pc", exc_pc, m_epc);
    end
  endtask

  task automatic model_step();
    logic adv;
    adv = m_vld && !stall;
    if (adv && m_exc == 0) m_cnt = m_cnt + 1;
    if (adv && m_exc != 0 && (!m_exc_vld || exc_clr)) begin
      m_exc_vld = 1; m_cause = m_exc; m_epc = m_pc;
    end else if (exc_clr) m_exc_vld = 0;
    if (flush) begin
      m_vld = 0; m_inst = NOP;
    end else if (!stall) begin
      m_vld = ma_vld; m_pc = ma_pc; m_inst = ma_inst; m_dat = ma_dat;
      m_lsb = ma_addr_lsb; m_exc = ma_exc;
    end
  endtask

  // Inputs change at posedge+1; outputs are checked at the negedge
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] d, input logic [1:0] lsb, input logic [1:0] exc);
    ma_vld = v; ma_pc = pc; ma_inst = inst; ma_dat = d; ma_addr_lsb = lsb; ma_exc = exc;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [2:0] f3);
    return {12'h0, 5'd1, f3, rd, opc};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rf_we", rf_we, 0);       chk("rst_rf_dst", rf_dst, 0);
    chk("rst_rf_dat", rf_dat, 0);     chk("rst_fwd_we", fwd_we, 0);
    chk("rst_fwd_dat", fwd_dat, 0);   chk("rst_retire", retire_vld, 0);
    chk("rst_retire_pc", retire_pc, 0); chk("rst_cnt", instret_cnt, 0);
    chk("rst_cnt_small", s_cnt, 0);   chk("rst_exc_vld", exc_vld, 0);
    chk("rst_exc_cause", exc_cause, 0); chk("rst_exc_pc", exc_pc, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] dat;
    logic [1:0]  lsb;
    logic        exp_we;
    logic [4:0]  exp_dst;
    logic [31:0] exp_dat;
    logic [63:0] exp_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [63:0] c0;
    tbl[0] = '{mk(OPC_LOAD, 5'd5, 3'b000),  32'h80FF_0000, 2'b11, 1, 5'd5,  32'hFFFF_FF80, 1};
    tbl[1] = '{mk(OPC_LOAD, 5'd6, 3'b101),  32'h8001_1234, 2'b10, 1, 5'd6,  32'h0000_8001, 2};
    tbl[2] = '{mk(OPC_OP,   5'd0, 3'b000),  32'h1234_5678, 2'b00, 0, 5'd0,  32'h0,         3};
    tbl[3] = '{mk(OPC_STORE,5'd7, 3'b010),  32'h1234_5678, 2'b00, 0, 5'd0,  32'h0,         4};
    tbl[4] = '{mk(OPC_LOAD, 5'd7, 3'b010),  32'h1234_5678, 2'b01, 1, 5'd7,  32'h1234_5678, 5};
    tbl[5] = '{mk(OPC_LOAD, 5'd8, 3'b000),  32'h0000_007F, 2'b00, 1, 5'd8,  32'h0000_007F, 6};
    tbl[6] = '{mk(OPC_LOAD, 5'd9, 3'b001),  32'h0000_8000, 2'b01, 1, 5'd9,  32'hFFFF_8000, 7};
    tbl[7] = '{mk(OPC_IMM,  5'd10, 3'b000), 32'hDEAD_BEEF, 2'b11, 1, 5'd10, 32'hDEAD_BEEF, 8};
    tbl[8] = '{mk(OPC_LOAD, 5'd11, 3'b011), 32'hCAFE_F00D, 2'b10, 1, 5'd11, 32'hCAFE_F00D, 9};
    tbl[9] = '{mk(OPC_BR,   5'd12, 3'b000), 32'h0000_0001, 2'b00, 0, 5'd0,  32'h0,         10};

    #1;
    do_reset();

    // Directed vectors: one instruction, then inspect it in writeback
    for (int i = 0; i < 10; i++) begin
      set_in(1, 32'h1000 + 32'(4 * i), tbl[i].inst, tbl[i].dat, tbl[i].lsb, 2'b00);
      cycle();
      set_in(0, 0, NOP, 0, 0, 0);
      #3;
      chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].exp_we);
      if (tbl[i].exp_we) begin
        chk($sformatf("tbl%0d_dst", i), rf_dst, tbl[i].exp_dst);
        chk($sformatf("tbl%0d_dat", i), rf_dat, tbl[i].exp_dat);
      end
      chk($sformatf("tbl%0d_ret", i), retire_vld, 1);
      cycle();
      chk($sformatf("tbl%0d_cnt", i), instret_cnt, tbl[i].exp_cnt);
    end

    // Held instruction retires once when stall drops
    set_in(1, 32'h100, mk(OPC_IMM, 5'd12, 3'b000), 32'h55, 0, 0);
    cycle();
    c0 = m_cnt;
    stall = 1;
    set_in(1, 32'h104, mk(OPC_IMM, 5'd13, 3'b000), 32'h66, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_we", rf_we, 0);
      chk("stall_ret", retire_vld, 0);
      cycle();
    end
    stall = 0;
    set_in(0, 0, NOP, 0, 0, 0);
    #3;
    chk("unstall_ret", retire_vld, 1);
    chk("unstall_pc", retire_pc, 32'h100);
    chk("unstall_dat", rf_dat, 32'h55);
    chk("unstall_cnt_before", instret_cnt, c0);
    cycle();
    chk("unstall_cnt_after", instret_cnt, c0 + 1);
    chk("unstall_once", retire_vld, 0);
    cycle();

    // Exception capture: first wins, clear coincident with a new event
    set_in(1, 32'h40, mk(OPC_LOAD, 5'd3, 3'b010), 32'h1, 0, 2'b01);
    cycle();
    set_in(1, 32'h44, mk(OPC_LOAD, 5'd4, 3'b010), 32'h2, 0, 2'b10);
    #3;
    chk("exc1_we", rf_we, 0);
    chk("exc1_ret", retire_vld, 0);
    cycle();
    set_in(0, 0, NOP, 0, 0, 0);
    #3;
    chk("exc1_vld", exc_vld, 1);
    chk("exc1_cause", exc_cause, 2'b01);
    chk("exc1_pc", exc_pc, 32'h40);
    chk("exc2_ret", retire_vld, 0);
    cycle();
    set_in(1, 32'h48, mk(OPC_LOAD, 5'd5, 3'b010), 32'h3, 0, 2'b11);
    #3;
    chk("exc2_ignored_pc", exc_pc, 32'h40);
    chk("exc2_ignored_cause", exc_cause, 2'b01);
    cycle();
    exc_clr = 1;
    set_in(0, 0, NOP, 0, 0, 0);
    cycle();
    exc_clr = 0;
    #3;
    chk("exc3_vld", exc_vld, 1);
    chk("exc3_pc", exc_pc, 32'h48);
    chk("exc3_cause", exc_cause, 2'b11);
    exc_clr = 1;
    cycle();
    exc_clr = 0;
    #3;
    chk("exc_cleared", exc_vld, 0);
    cycle();

    // Flush together with stall: bubble, nothing commits
    set_in(1, 32'h200, mk(OPC_IMM, 5'd14, 3'b000), 32'h77, 0, 0);
    cycle();
    flush = 1; stall = 1;
    set_in(1, 32'h204, mk(OPC_IMM, 5'd15, 3'b000), 32'h88, 0, 0);
    #3;
    chk("fs_ret_held", retire_vld, 0);
    cycle();
    flush = 0; stall = 0;
    set_in(0, 0, NOP, 0, 0, 0);
    #3;
    chk("fs_bubble_ret", retire_vld, 0);
    chk("fs_bubble_we", rf_we, 0);
    cycle();

    // Narrow counter wraps from all-ones to zero
    for (int i = 0; i < 20; i++) begin
      if (s_cnt == 3'd7) break;
      set_in(1, 32'h300, mk(OPC_IMM, 5'd1, 3'b000), 0, 0, 0);
      cycle();
      set_in(0, 0, NOP, 0, 0, 0);
      cycle();
    end
    chk("wrap_reach_ones", s_cnt, 3'd7);
    set_in(1, 32'h304, mk(OPC_IMM, 5'd1, 3'b000), 0, 0, 0);
    cycle();
    set_in(0, 0, NOP, 0, 0, 0);
    cycle();
    chk("wrap_to_zero", s_cnt, 3'd0);

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      logic [6:0] opc;
      logic [4:0] rd;
      case ($urandom_range(0, 4))
        0: opc = OPC_LOAD;  1: opc = OPC_STORE; 2: opc = OPC_BR;
        3: opc = OPC_OP;    default: opc = OPC_IMM;
      endcase
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      set_in($urandom_range(0, 3) != 0, {$urandom, 2'b00} , mk(opc, rd, 3'($urandom)),
             $urandom, 2'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      exc_clr = ($urandom_range(0, 9) == 0);
      if (i == 200) do_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
